// File: rtl/count_frame_serializer.sv
// count_frame_serializer
//   Periodically snapshots a 16-bit counter value and emits it on an 8-bit bus
//   as a framed byte sequence: HEADER, count[15:8], count[7:0]. Each byte is
//   held for BYTE_HOLD cycles. Sampling is self-timed by an internal divider
//   that produces one tick every SAMPLE_PERIOD cycles while en is high.
//
//   Optional build macro: COUNT_FRAME_CHECKSUM_EN
//     When defined, a fourth byte (HEADER ^ hi ^ lo) follows the low byte.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   en           in   sampling enable (divider held at 0 while low)
//   count_in     in   16-bit counter value to sample
//   data_out     out  current frame byte, 8'h00 when idle
//   data_strobe  out  high on the first cycle of each byte
//   frame_active out  high while a frame is being emitted
//   overrun      out  sticky flag: a sample tick was dropped

module count_frame_serializer #(
    parameter int unsigned SAMPLE_PERIOD = 1024,
    parameter int unsigned BYTE_HOLD     = 4,
    parameter logic [7:0]  HEADER        = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] count_in,
    output logic [7:0]  data_out,
    output logic        data_strobe,
    output logic        frame_active,
    output logic        overrun
);

    localparam int unsigned DIV_W  = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int unsigned HOLD_W = (BYTE_HOLD > 1) ? $clog2(BYTE_HOLD) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_PERIOD - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(BYTE_HOLD - 1);

`ifdef COUNT_FRAME_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, HDR, HI, LO, CHK} state_t;
    localparam state_t LAST_BYTE = CHK;
`else
    typedef enum logic [1:0] {IDLE, HDR, HI, LO} state_t;
    localparam state_t LAST_BYTE = LO;
`endif

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [15:0]        snap_q, snap_d;

    logic               tick;
    logic               hold_done;
    logic               accept;

    logic [7:0]         data_d;
    logic               strobe_d;
    logic               active_d;
    logic               overrun_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            div_q        <= '0;
            hold_q       <= '0;
            snap_q       <= '0;
            data_out     <= '0;
            data_strobe  <= 1'b0;
            frame_active <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            hold_q       <= hold_d;
            snap_q       <= snap_d;
            data_out     <= data_d;
            data_strobe  <= strobe_d;
            frame_active <= active_d;
            overrun      <= overrun_d;
        end
    end

    always_comb begin
        tick      = en && (div_q == DIV_LAST);
        hold_done = (hold_q == HOLD_LAST);
        // A tick is taken when idle, or in the final cycle of the last byte so
        // that back-to-back frames run without a gap.
        accept    = tick && ((state_q == IDLE) || ((state_q == LAST_BYTE) && hold_done));

        if (!en) begin
            div_d = '0;
        end else if (div_q == DIV_LAST) begin
            div_d = '0;
        end else begin
            div_d = div_q + 1'b1;
        end

        state_d = state_q;
        hold_d  = hold_q;
        snap_d  = snap_q;

        if (state_q != IDLE) begin
            hold_d = hold_done ? '0 : hold_q + 1'b1;
        end

        case (state_q)
            IDLE: state_d = IDLE;
            HDR:  if (hold_done) state_d = HI;
            HI:   if (hold_done) state_d = LO;
`ifdef COUNT_FRAME_CHECKSUM_EN
            LO:   if (hold_done) state_d = CHK;
            CHK:  if (hold_done) state_d = IDLE;
`else
            LO:   if (hold_done) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d = HDR;
            hold_d  = '0;
            snap_d  = count_in;
        end

        overrun_d = overrun | (tick & ~accept);

        // Outputs are registered from the next-state values so that a tick in
        // cycle T shows the header with its strobe in cycle T+1.
        data_d = '0;
        case (state_d)
            HDR:     data_d = HEADER;
            HI:      data_d = snap_d[15:8];
            LO:      data_d = snap_d[7:0];
`ifdef COUNT_FRAME_CHECKSUM_EN
            CHK:     data_d = HEADER ^ snap_d[15:8] ^ snap_d[7:0];
`endif
            default: data_d = '0;
        endcase

        active_d = (state_d != IDLE);
        strobe_d = active_d && (hold_d == '0);
    end

endmodule

// File: tb/tb_count_frame_serializer.sv
module tb_count_frame_serializer;

`ifdef COUNT_FRAME_CHECKSUM_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif
    localparam int NI = 4;
    localparam logic [7:0] HDRB = 8'hA5;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                en  = 1'b0;
    logic [15:0]         count_in = '0;
    logic [NI-1:0][7:0]  dout;
    logic [NI-1:0]       strb;
    logic [NI-1:0]       actv;
    logic [NI-1:0]       ovr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Instance 0: basic timing; 1: exact back-to-back; 2: overrun; 3: BYTE_HOLD=1
    count_frame_serializer #(.SAMPLE_PERIOD(16), .BYTE_HOLD(2), .HEADER(8'hA5)) u0 (
        .clk(clk), .rst(rst), .en(en), .count_in(count_in),
        .data_out(dout[0]), .data_strobe(strb[0]), .frame_active(actv[0]), .overrun(ovr[0]));
    count_frame_serializer #(.SAMPLE_PERIOD(NB*2), .BYTE_HOLD(2), .HEADER(8'hA5)) u1 (
        .clk(clk), .rst(rst), .en(en), .count_in(count_in),
        .data_out(dout[1]), .data_strobe(strb[1]), .frame_active(actv[1]), .overrun(ovr[1]));
    count_frame_serializer #(.SAMPLE_PERIOD(4), .BYTE_HOLD(2), .HEADER(8'hA5)) u2 (
        .clk(clk), .rst(rst), .en(en), .count_in(count_in),
        .data_out(dout[2]), .data_strobe(strb[2]), .frame_active(actv[2]), .overrun(ovr[2]));
    count_frame_serializer #(.SAMPLE_PERIOD(7), .BYTE_HOLD(1), .HEADER(8'hA5)) u3 (
        .clk(clk), .rst(rst), .en(en), .count_in(count_in),
        .data_out(dout[3]), .data_strobe(strb[3]), .frame_active(actv[3]), .overrun(ovr[3]));

    function automatic int per_of(int k);
        case (k)
            0:       return 16;
            1:       return NB * 2;
            2:       return 4;
            default: return 7;
        endcase
    endfunction

    function automatic int bh_of(int k);
        return (k == 3) ? 1 : 2;
    endfunction

    function automatic logic [7:0] frame_byte(logic [15:0] snap, int idx);
        logic [7:0] hi, lo;
        hi = snap[15:8];
        lo = snap[7:0];
        case (idx)
            0:       return HDRB;
            1:       return hi;
            2:       return lo;
            default: return HDRB ^ hi ^ lo;
        endcase
    endfunction

    // Reference model: each frame is a run of NB*BYTE_HOLD cycles starting the
    // cycle after an accepted tick; m_pos is the cycle offset inside it (-1 idle).
    int          m_div  [NI];
    int          m_pos  [NI];
    logic [15:0] m_snap [NI];
    logic        m_ovr  [NI];

    task automatic model_edge();
        for (int k = 0; k < NI; k++) begin
            int  p, fl;
            bit  tk, acc;
            p  = per_of(k);
            fl = NB * bh_of(k);
            if (rst) begin
                m_div[k] = 0; m_pos[k] = -1; m_snap[k] = '0; m_ovr[k] = 1'b0;
            end else begin
                tk = en && (m_div[k] == p - 1);
                m_div[k] = en ? (m_div[k] + 1) % p : 0;
                acc = tk && (m_pos[k] < 0 || m_pos[k] == fl - 1);
                if (tk && !acc) m_ovr[k] = 1'b1;
                if (acc) begin
                    m_pos[k] = 0;
                    m_snap[k] = count_in;
                end else if (m_pos[k] >= 0) begin
                    m_pos[k] = m_pos[k] + 1;
                    if (m_pos[k] == fl) m_pos[k] = -1;
                end
            end
        end
    endtask

    function automatic logic [7:0] m_data(int k);
        if (m_pos[k] < 0) return 8'h00;
        return frame_byte(m_snap[k], m_pos[k] / bh_of(k));
    endfunction

    function automatic logic m_strb(int k);
        return (m_pos[k] >= 0) && (m_pos[k] % bh_of(k) == 0);
    endfunction

    function automatic logic m_act(int k);
        return m_pos[k] >= 0;
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0;
        step();
        rst = 1'b0; en = 1'b1; count_in = 16'h5555;
        repeat (10) step();
        rst = 1'b1; count_in = 16'hFFFF;
        for (int r = 0; r < 2; r++) begin
            step();
            for (int k = 0; k < NI; k++) begin
                n_cmp++;
                if (dout[k] !== 8'h00 || strb[k] !== 1'b0 || actv[k] !== 1'b0 || ovr[k] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL reset_outputs inst=%0d got d=%h s=%b a=%b o=%b want all 0",
                             k, dout[k], strb[k], actv[k], ovr[k]);
                end
            end
        end
        rst = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            step();
            n_cmp++;
            if (strb[0] !== (c == 16) || actv[0] !== (c >= 16)) begin
                n_bad++;
                $display("FAIL reset_div_restart c=%0d got s=%b a=%b want s=%b a=%b",
                         c, strb[0], actv[0], c == 16, c >= 16);
            end
        end
    endtask

    task automatic test_basic_frame();
        logic [7:0] exp_d;
        logic       exp_a, exp_s;
        en = 1'b1; count_in = 16'h1234;
        do_reset();
        for (int c = 1; c <= 16 + NB * 2 + 1; c++) begin
            step();
            exp_a = (c >= 16) && (c < 16 + NB * 2);
            exp_s = exp_a && ((c - 16) % 2 == 0);
            exp_d = exp_a ? frame_byte(16'h1234, (c - 16) / 2) : 8'h00;
            n_cmp++;
            if (dout[0] !== exp_d || strb[0] !== exp_s || actv[0] !== exp_a) begin
                n_bad++;
                $display("FAIL basic_frame c=%0d got d=%h s=%b a=%b want d=%h s=%b a=%b",
                         c, dout[0], strb[0], actv[0], exp_d, exp_s, exp_a);
            end
        end
`ifdef COUNT_FRAME_CHECKSUM_EN
        n_cmp++;
        if (frame_byte(16'h1234, 3) !== 8'h83) begin
            n_bad++;
            $display("FAIL checksum_const got %h want 83", frame_byte(16'h1234, 3));
        end
`endif
    endtask

    task automatic test_snapshot_hold();
        logic [7:0]  exp_d;
        logic [15:0] snap;
        int          start;
        en = 1'b1; count_in = 16'h1234;
        do_reset();
        for (int c = 1; c <= 32 + NB * 2 + 1; c++) begin
            step();
            start = (c >= 32) ? 32 : 16;
            snap  = (c >= 32) ? 16'hBEEF : 16'h1234;
            exp_d = (c >= start && c < start + NB * 2) ? frame_byte(snap, (c - start) / 2) : 8'h00;
            n_cmp++;
            if (dout[0] !== exp_d) begin
                n_bad++;
                $display("FAIL snapshot_hold c=%0d got %h want %h", c, dout[0], exp_d);
            end
            if (c == 17) count_in = 16'hBEEF;
        end
    endtask

    task automatic test_back_to_back();
        int p;
        p = NB * 2;
        en = 1'b1; count_in = $urandom;
        do_reset();
        for (int c = 1; c <= p * 8; c++) begin
            step();
            if (c >= p) begin
                n_cmp++;
                if (actv[1] !== 1'b1 || strb[1] !== ((c - p) % 2 == 0)) begin
                    n_bad++;
                    $display("FAIL b2b_active c=%0d got a=%b s=%b want a=1 s=%b",
                             c, actv[1], strb[1], (c - p) % 2 == 0);
                end
                if ((c - p) % p == 0) begin
                    n_cmp++;
                    if (dout[1] !== HDRB) begin
                        n_bad++;
                        $display("FAIL b2b_header c=%0d got %h want %h", c, dout[1], HDRB);
                    end
                end
            end
            n_cmp++;
            if (ovr[1] !== 1'b0 || dout[1] !== m_data(1)) begin
                n_bad++;
                $display("FAIL b2b_model c=%0d got d=%h o=%b want d=%h o=0", c, dout[1], ovr[1], m_data(1));
            end
            count_in = $urandom;
        end
    endtask

    task automatic test_overrun();
        en = 1'b1; count_in = $urandom;
        do_reset();
        for (int c = 1; c <= 60; c++) begin
            step();
            n_cmp++;
            if (ovr[2] !== (c >= 8)) begin
                n_bad++;
                $display("FAIL overrun_flag c=%0d got %b want %b", c, ovr[2], c >= 8);
            end
            n_cmp++;
            if (dout[2] !== m_data(2) || strb[2] !== m_strb(2) || actv[2] !== m_act(2)) begin
                n_bad++;
                $display("FAIL overrun_frame c=%0d got d=%h s=%b a=%b want d=%h s=%b a=%b",
                         c, dout[2], strb[2], actv[2], m_data(2), m_strb(2), m_act(2));
            end
            count_in = $urandom;
        end
    endtask

    task automatic test_reset_mid_frame();
        en = 1'b1; count_in = 16'h1234;
        do_reset();
        repeat (18) step();
        n_cmp++;
        if (dout[0] !== 8'h12 || strb[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_in_hi got d=%h s=%b want d=12 s=1", dout[0], strb[0]);
        end
        rst = 1'b1;
        step();
        n_cmp++;
        if (dout[0] !== 8'h00 || actv[0] !== 1'b0 || strb[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_abandon got d=%h a=%b s=%b want 00 0 0", dout[0], actv[0], strb[0]);
        end
        rst = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            step();
            n_cmp++;
            if (actv[0] !== (c >= 16)) begin
                n_bad++;
                $display("FAIL midrst_no_resume c=%0d got a=%b want %b", c, actv[0], c >= 16);
            end
        end
    endtask

    task automatic test_random();
        en = 1'b1; count_in = $urandom;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            count_in = $urandom;
            if ($urandom_range(0, 15) == 0) en = ~en;
            rst = ($urandom_range(0, 199) == 0);
            step();
            for (int k = 0; k < NI; k++) begin
                n_cmp++;
                if (dout[k] !== m_data(k) || strb[k] !== m_strb(k) ||
                    actv[k] !== m_act(k) || ovr[k] !== m_ovr[k]) begin
                    n_bad++;
                    $display("FAIL random c=%0d inst=%0d got d=%h s=%b a=%b o=%b want d=%h s=%b a=%b o=%b",
                             c, k, dout[k], strb[k], actv[k], ovr[k],
                             m_data(k), m_strb(k), m_act(k), m_ovr[k]);
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            m_div[k] = 0; m_pos[k] = -1; m_snap[k] = '0; m_ovr[k] = 1'b0;
        end
        test_reset();
        test_basic_frame();
        test_snapshot_hold();
        test_back_to_back();
        test_overrun();
        test_reset_mid_frame();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/count_frame_serializer.md
Name: count_frame_serializer

Overview:
- Downstream consumer of the 16-bit free-running counter value.
- Periodically snapshots the count and emits it on an 8-bit output bus as a framed byte sequence: header, high byte, low byte.
- The output bus is intended to drive the dedicated output pins so an external logic analyser or MCU can capture counter samples.
- Sampling is self-timed by an internal divider. Frame bytes are held for a programmable number of cycles each.

Parameters:
- SAMPLE_PERIOD, 1024: cycles between sample ticks. Must be ≥ 2.
- BYTE_HOLD, 4: cycles each frame byte is held on data_out. Must be ≥ 1.
- HEADER, 8'hA5: first byte of every frame.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  sampling enable.
- count_in  in  16  counter value to sample.
- data_out  out  8  current frame byte. 8'h00 when idle.
- data_strobe  out  1  high on the first cycle of each byte.
- frame_active  out  1  high while a frame is being emitted.
- overrun  out  1  sticky; a sample tick was dropped.

Behaviour:
- Reset: all outputs are registered and driven to 0 on the cycle after rst is sampled high.
  - The divider clears to 0, the state goes to IDLE, the hold counter clears to 0, and the snapshot clears to 0.
  - rst overrides every other input, including mid-frame; the frame is abandoned with no partial completion.
- Divider: counts 0..SAMPLE_PERIOD-1 while en=1 and wraps.
  - A tick is asserted internally in the cycle the divider equals SAMPLE_PERIOD-1.
  - When en=0 the divider is forced to 0 and no ticks occur. A frame already in progress still completes.
  - First tick after en rises: SAMPLE_PERIOD cycles later.
- States: IDLE, HDR, HI, LO (plus CHK, see Optional Feature). Each byte state lasts exactly BYTE_HOLD cycles, timed by a hold counter running 0..BYTE_HOLD-1.
- Tick acceptance:
  - A tick is accepted if the state is IDLE, or if the state is the last byte state with the hold counter at BYTE_HOLD-1 (back-to-back frames).
  - On acceptance, count_in is latched into the 16-bit snapshot and the next state is HDR.
  - Latency: tick in cycle T → HDR with data_strobe=1 in cycle T+1.
- Transitions:
  - HDR→HI→LO after BYTE_HOLD cycles each.
  - After the last byte state, go to IDLE, or to HDR if a tick is accepted that cycle.
- data_out:
  - HEADER in HDR.
  - snapshot[15:8] in HI.
  - snapshot[7:0] in LO.
  - 8'h00 in IDLE.
- data_strobe is 1 only when the hold counter is 0 in a byte state.
- frame_active is 1 in every non-IDLE state. It stays continuously high across back-to-back frames.
- Snapshot stability: the frame carries the snapshot. Changes on count_in during a frame do not affect it.
- Overrun: a tick arriving when it cannot be accepted is dropped, and overrun is set to 1 the next cycle. It stays 1 until rst and does not alter the frame in progress.
- Frame length: 3×BYTE_HOLD cycles, or 4×BYTE_HOLD with the checksum. With SAMPLE_PERIOD equal to the frame length, frames run back-to-back with no overrun.

Optional Feature:
- Macro: COUNT_FRAME_CHECKSUM_EN.
- Defined: a fourth byte state CHK follows LO.
  - In CHK, data_out = HEADER ^ snapshot[15:8] ^ snapshot[7:0], held BYTE_HOLD cycles with a strobe.
  - CHK becomes the last byte state for back-to-back acceptance.
- Undefined: LO is the last state. The CHK state and XOR logic are not synthesized.

Test Plan:
- Reset: assert rst for 2 cycles with en=1 and count_in=16'hFFFF → all outputs 0. Divider restarts at 0 after release.
- Basic frame: SAMPLE_PERIOD=16, BYTE_HOLD=2, en=1 from cycle 0, count_in=16'h1234.
  - Tick at cycle 15.
  - Cycles 16-17: data_out=A5. Cycles 18-19: data_out=12. Cycles 20-21: data_out=34.
  - data_strobe high at cycles 16, 18 and 20.
  - Cycle 22: data_out=00, frame_active=0.
- Snapshot hold: same configuration; change count_in to 16'hBEEF at cycle 17 → frame still emits 12, 34. The next frame emits BE, EF.
- Back-to-back: SAMPLE_PERIOD=6, BYTE_HOLD=2 → frame_active stays 1 continuously, an HDR strobe occurs every 6 cycles, and overrun stays 0.
- Overrun: SAMPLE_PERIOD=4, BYTE_HOLD=2 → overrun=1 after the first dropped tick and stays 1. Emitted frames remain well-formed.
- Reset mid-frame and checksum: assert rst during HI → data_out=00 and frame_active=0 the next cycle. With COUNT_FRAME_CHECKSUM_EN and count_in=16'h1234, the 4th byte = A5^12^34 = 8'h83.
